// File: rtl/dm_lane_delay_ctrl.sv
// dm_lane_delay_ctrl
// Tap-step controller for the DDR4 DM lane output delay line. Turns
// load/increment/decrement requests into spaced MOVE/DIRECTION/LOAD strobes
// for the lane IOD, tracks the tap position and returns a status/tap response.
//
// Handshakes (both sides): a transfer happens on a rising FAB_CLK edge where
// valid and ready are both high. REQ_VALID seen while REQ_READY is low is
// ignored, so the source must hold the request until it is taken. RSP_VALID
// stays high with RSP_STATUS/RSP_TAP frozen until RSP_READY is seen high.
module dm_lane_delay_ctrl #(
    parameter int unsigned TAP_MAX  = 255,
    parameter int unsigned MOVE_GAP = 4,
    parameter int unsigned LOAD_TAP = 1
) (
    input  logic       FAB_CLK,
    input  logic       SYNC_RST,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [1:0] REQ_CMD,
    input  logic [7:0] REQ_STEPS,
    output logic       RSP_VALID,
    input  logic       RSP_READY,
    output logic [1:0] RSP_STATUS,
    output logic [7:0] RSP_TAP,
    output logic       DELAY_LINE_MOVE_0,
    output logic       DELAY_LINE_DIRECTION_0,
    output logic       DELAY_LINE_LOAD_0,
    input  logic       DELAY_LINE_OUT_OF_RANGE_0,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_MOVE  = 3'd2,
        ST_GAP   = 3'd3,
        ST_LOAD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_INC  = 2'b01;
    localparam logic [1:0] CMD_DEC  = 2'b10;

    localparam logic [1:0] STAT_OK     = 2'b00;
    localparam logic [1:0] STAT_RANGE  = 2'b01;
    localparam logic [1:0] STAT_LIMIT  = 2'b10;
    localparam logic [1:0] STAT_BADCMD = 2'b11;

    localparam logic [7:0] TAP_MAX_V  = 8'(TAP_MAX);
    localparam logic [7:0] LOAD_TAP_V = 8'(LOAD_TAP);
    // GAP lasts MOVE_GAP-1 cycles, so it counts down from MOVE_GAP-2 to 0.
    localparam logic [3:0] GAP_START  = 4'(MOVE_GAP - 2);
    // LOAD covers the strobe cycle plus MOVE_GAP-1 wait cycles.
    localparam logic [3:0] LOAD_START = 4'(MOVE_GAP - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] tap;
    logic [7:0] tap_nxt;
    logic [7:0] remain;
    logic [7:0] remain_nxt;
    logic [3:0] gap_cnt;
    logic [3:0] gap_nxt;
    logic       dir_nxt;
    logic [1:0] status_nxt;
    logic [7:0] rsp_tap_nxt;
    logic       at_limit;
    logic [7:0] tap_step;
    logic [7:0] tap_undo;

    assign dbg_state = state;

    // Bound check and the +/-1 neighbours of the tap in the current direction.
    always_comb begin
        at_limit = DELAY_LINE_DIRECTION_0 ? (tap == TAP_MAX_V) : (tap == 8'd0);
        tap_step = DELAY_LINE_DIRECTION_0 ? (tap + 8'd1) : (tap - 8'd1);
        tap_undo = DELAY_LINE_DIRECTION_0 ? (tap - 8'd1) : (tap + 8'd1);
    end

    // Next-state and next-value logic for every register.
    always_comb begin
        state_nxt   = state;
        tap_nxt     = tap;
        remain_nxt  = remain;
        gap_nxt     = gap_cnt;
        dir_nxt     = DELAY_LINE_DIRECTION_0;
        status_nxt  = RSP_STATUS;
        rsp_tap_nxt = RSP_TAP;
        case (state)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    if (REQ_CMD == CMD_LOAD) begin
                        // The IOD returns to its static delay on LOAD.
                        tap_nxt   = LOAD_TAP_V;
                        gap_nxt   = LOAD_START;
                        state_nxt = ST_LOAD;
                    end else if ((REQ_CMD != CMD_INC) && (REQ_CMD != CMD_DEC)) begin
                        status_nxt  = STAT_BADCMD;
                        rsp_tap_nxt = tap;
                        state_nxt   = ST_DONE;
                    end else if (REQ_STEPS == 8'd0) begin
                        status_nxt  = STAT_OK;
                        rsp_tap_nxt = tap;
                        state_nxt   = ST_DONE;
                    end else begin
                        // Direction only ever changes here, ahead of any move.
                        dir_nxt    = (REQ_CMD == CMD_INC);
                        remain_nxt = REQ_STEPS;
                        state_nxt  = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                // Already at the bound: refuse without pulsing MOVE.
                if (at_limit) begin
                    status_nxt  = STAT_LIMIT;
                    rsp_tap_nxt = tap;
                    state_nxt   = ST_DONE;
                end else begin
                    state_nxt = ST_MOVE;
                end
            end
            ST_MOVE: begin
                tap_nxt    = tap_step;
                remain_nxt = remain - 8'd1;
                gap_nxt    = GAP_START;
                state_nxt  = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt != 4'd0) begin
                    gap_nxt = gap_cnt - 4'd1;
                end else if (DELAY_LINE_OUT_OF_RANGE_0) begin
                    // The IOD refused the last step, so it is not counted.
                    tap_nxt     = tap_undo;
                    status_nxt  = STAT_RANGE;
                    rsp_tap_nxt = tap_undo;
                    state_nxt   = ST_DONE;
                end else if (remain == 8'd0) begin
                    status_nxt  = STAT_OK;
                    rsp_tap_nxt = tap;
                    state_nxt   = ST_DONE;
                end else if (at_limit) begin
                    status_nxt  = STAT_LIMIT;
                    rsp_tap_nxt = tap;
                    state_nxt   = ST_DONE;
                end else begin
                    state_nxt = ST_MOVE;
                end
            end
            ST_LOAD: begin
                if (gap_cnt != 4'd0) begin
                    gap_nxt = gap_cnt - 4'd1;
                end else begin
                    status_nxt  = STAT_OK;
                    rsp_tap_nxt = tap;
                    state_nxt   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (RSP_READY) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and all outputs registered; strobes decoded from next state.
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            state                  <= ST_IDLE;
            tap                    <= LOAD_TAP_V;
            remain                 <= 8'd0;
            gap_cnt                <= 4'd0;
            REQ_READY              <= 1'b1;
            RSP_VALID              <= 1'b0;
            RSP_STATUS             <= STAT_OK;
            RSP_TAP                <= LOAD_TAP_V;
            DELAY_LINE_MOVE_0      <= 1'b0;
            DELAY_LINE_DIRECTION_0 <= 1'b0;
            DELAY_LINE_LOAD_0      <= 1'b0;
        end else begin
            state                  <= state_nxt;
            tap                    <= tap_nxt;
            remain                 <= remain_nxt;
            gap_cnt                <= gap_nxt;
            REQ_READY              <= (state_nxt == ST_IDLE);
            RSP_VALID              <= (state_nxt == ST_DONE);
            RSP_STATUS             <= status_nxt;
            RSP_TAP                <= rsp_tap_nxt;
            DELAY_LINE_MOVE_0      <= (state_nxt == ST_MOVE);
            DELAY_LINE_DIRECTION_0 <= dir_nxt;
            DELAY_LINE_LOAD_0      <= (state == ST_IDLE) && (state_nxt == ST_LOAD);
        end
    end

endmodule

// File: tb/tb_dm_lane_delay_ctrl.sv
// Bench for dm_lane_delay_ctrl: directed vector table, reset corner cases and
// randomized requests checked against a plain arithmetic tap model.
module tb_dm_lane_delay_ctrl;

  localparam int G        = 4;
  localparam int TAP_MAX  = 255;
  localparam int LOAD_TAP = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_cmd;
  logic [7:0] req_steps;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_status;
  logic [7:0] rsp_tap;
  logic       dl_move;
  logic       dl_dir;
  logic       dl_load;
  logic       dl_oor;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cur_tap;
  logic [15:0] exp_q[$];

  dm_lane_delay_ctrl #(.TAP_MAX(TAP_MAX), .MOVE_GAP(G), .LOAD_TAP(LOAD_TAP)) dut (
    .FAB_CLK                   (clk),
    .SYNC_RST                  (rst),
    .REQ_VALID                 (req_valid),
    .REQ_READY                 (req_ready),
    .REQ_CMD                   (req_cmd),
    .REQ_STEPS                 (req_steps),
    .RSP_VALID                 (rsp_valid),
    .RSP_READY                 (rsp_ready),
    .RSP_STATUS                (rsp_status),
    .RSP_TAP                   (rsp_tap),
    .DELAY_LINE_MOVE_0         (dl_move),
    .DELAY_LINE_DIRECTION_0    (dl_dir),
    .DELAY_LINE_LOAD_0         (dl_load),
    .DELAY_LINE_OUT_OF_RANGE_0 (dl_oor),
    .dbg_state                 (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] steps;
    int         flag_after;
    logic [1:0] status;
    int         tap;
    int         moves;
    int         rsp_off;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_reset(input string name);
    check({name, " req_ready"}, int'(req_ready), 1);
    check({name, " rsp_valid"}, int'(rsp_valid), 0);
    check({name, " rsp_status"}, int'(rsp_status), 0);
    check({name, " rsp_tap"}, int'(rsp_tap), LOAD_TAP);
    check({name, " move"}, int'(dl_move), 0);
    check({name, " dir"}, int'(dl_dir), 0);
    check({name, " load"}, int'(dl_load), 0);
  endtask

  // Reference: walks the tap one step at a time by the controller's rules.
  task automatic model(input logic [1:0] cmd, input int steps, input int flag_after,
                       input int start, output logic [1:0] st, output int tap,
                       output int moves, output int rsp_off);
    int d;
    tap = start;
    moves = 0;
    st = 2'd0;
    if (cmd == 2'd3) begin
      st = 2'd3;
      rsp_off = 1;
    end else if (cmd == 2'd0) begin
      tap = LOAD_TAP;
      rsp_off = 1 + G;
    end else if (steps == 0) begin
      rsp_off = 1;
    end else begin
      d = (cmd == 2'd1) ? 1 : -1;
      if ((d > 0 && tap == TAP_MAX) || (d < 0 && tap == 0)) begin
        st = 2'd2;
        rsp_off = 2;
      end else begin
        for (int i = 0; i < steps; i++) begin
          tap += d;
          moves++;
          if (flag_after != 0 && moves == flag_after) begin
            tap -= d;
            st = 2'd1;
            break;
          end
          if (moves == steps) break;
          if ((d > 0 && tap == TAP_MAX) || (d < 0 && tap == 0)) begin
            st = 2'd2;
            break;
          end
        end
        rsp_off = 2 + moves * G;
      end
    end
  endtask

  // driver + per-cycle monitor for one request; called at a negedge
  task automatic run_txn(input logic [1:0] cmd, input logic [7:0] steps,
                         input int flag_after, input logic [1:0] exp_st,
                         input int exp_tap, input int exp_moves, input int exp_off,
                         input int rdy_delay, input string name);
    int  wait_cnt;
    int  off;
    int  moves_seen;
    bit  got_rsp;
    logic [15:0] e;
    exp_q.delete();
    for (int i = 0; i < exp_moves; i++) exp_q.push_back(16'(2 + i * G));
    req_cmd = cmd;
    req_steps = steps;
    req_valid = 1'b1;
    dl_oor = 1'b0;
    wait_cnt = 0;
    while (!req_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    check({name, " accept"}, int'(req_ready), 1);
    off = 0;
    moves_seen = 0;
    got_rsp = 1'b0;
    while (!got_rsp && off < exp_off + 20) begin
      @(negedge clk);
      off++;
      if (off == 1) begin
        check({name, " busy"}, int'(req_ready), 0);
        if ((cmd == 2'd1 || cmd == 2'd2) && steps != 8'd0)
          check({name, " dir"}, int'(dl_dir), int'(cmd == 2'd1));
        req_valid = 1'b0;
        req_cmd = 2'($urandom_range(0, 3));
      end
      if (dl_move) begin
        moves_seen++;
        if (exp_q.size() == 0) begin
          check({name, " extra move at"}, off, -1);
        end else begin
          e = exp_q.pop_front();
          check({name, " move cycle"}, off, int'(e));
        end
        check({name, " move dir"}, int'(dl_dir), int'(cmd == 2'd1));
        if (flag_after > 0 && moves_seen == flag_after) dl_oor = 1'b1;
      end
      if (dl_load) check({name, " load cycle"}, off, (cmd == 2'd0) ? 1 : -1);
      if (dl_move && dl_load) check({name, " move+load"}, 1, 0);
      if (rsp_valid) begin
        got_rsp = 1'b1;
        check({name, " rsp cycle"}, off, exp_off);
        check({name, " status"}, int'(rsp_status), int'(exp_st));
        check({name, " tap"}, int'(rsp_tap), exp_tap);
      end
    end
    check({name, " rsp seen"}, int'(got_rsp), 1);
    check({name, " move count"}, moves_seen, exp_moves);
    dl_oor = 1'b0;
    for (int i = 0; i < rdy_delay; i++) begin
      @(negedge clk);
      check({name, " hold valid"}, int'(rsp_valid), 1);
      check({name, " hold status"}, int'(rsp_status), int'(exp_st));
      check({name, " hold tap"}, int'(rsp_tap), exp_tap);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, " rsp drop"}, int'(rsp_valid), 0);
    check({name, " idle ready"}, int'(req_ready), 1);
  endtask

  task automatic run_model(input logic [1:0] cmd, input int steps, input int flag_after,
                           input int rdy_delay, input string name);
    logic [1:0] st;
    int tap, moves, off;
    model(cmd, steps, flag_after, cur_tap, st, tap, moves, off);
    run_txn(cmd, 8'(steps), flag_after, st, tap, moves, off, rdy_delay, name);
    cur_tap = tap;
  endtask

  initial begin
    int rsp_cnt;
    logic [1:0] rc;
    int rs, rf;

    vecs[0]  = '{2'd1, 8'd3,   0, 2'd0, 4,   3,   14};
    vecs[1]  = '{2'd0, 8'd0,   0, 2'd0, 1,   0,   5};
    vecs[2]  = '{2'd2, 8'd5,   0, 2'd2, 0,   1,   6};
    vecs[3]  = '{2'd2, 8'd1,   0, 2'd2, 0,   0,   2};
    vecs[4]  = '{2'd0, 8'd0,   0, 2'd0, 1,   0,   5};
    vecs[5]  = '{2'd1, 8'd10,  2, 2'd1, 2,   2,   10};
    vecs[6]  = '{2'd3, 8'd7,   0, 2'd3, 2,   0,   1};
    vecs[7]  = '{2'd1, 8'd0,   0, 2'd0, 2,   0,   1};
    vecs[8]  = '{2'd2, 8'd2,   0, 2'd0, 0,   2,   10};
    vecs[9]  = '{2'd1, 8'd1,   1, 2'd1, 0,   1,   6};
    vecs[10] = '{2'd1, 8'd1,   0, 2'd0, 1,   1,   6};
    vecs[11] = '{2'd1, 8'd255, 0, 2'd2, 255, 254, 1018};
    vecs[12] = '{2'd1, 8'd1,   0, 2'd2, 255, 0,   2};
    vecs[13] = '{2'd2, 8'd1,   0, 2'd0, 254, 1,   6};
    vecs[14] = '{2'd0, 8'd9,   0, 2'd0, 1,   0,   5};
    vecs[15] = '{2'd2, 8'd0,   0, 2'd0, 1,   0,   1};

    rst = 1'b1;
    req_valid = 1'b0;
    req_cmd = 2'd0;
    req_steps = 8'd0;
    rsp_ready = 1'b0;
    dl_oor = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    cur_tap = LOAD_TAP;

    // directed vector table
    for (int i = 0; i < 16; i++) begin
      run_txn(vecs[i].cmd, vecs[i].steps, vecs[i].flag_after, vecs[i].status,
              vecs[i].tap, vecs[i].moves, vecs[i].rsp_off, i % 3,
              $sformatf("vec%0d", i));
      cur_tap = vecs[i].tap;
    end

    // reset in the cycle of the 2nd MOVE of an increment-5
    req_cmd = 2'd1;
    req_steps = 8'd5;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rs = 0;
    for (int i = 0; i < 40 && rs < 2; i++) begin
      @(negedge clk);
      if (dl_move) rs++;
    end
    check("midburst moves before reset", rs, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("midburst");
    rsp_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rsp_valid || dl_move) rsp_cnt++;
    end
    check("midburst quiet after reset", rsp_cnt, 0);
    cur_tap = LOAD_TAP;
    run_model(2'd1, 0, 0, 0, "midburst tap");

    // reset while a BADCMD response is being held
    req_cmd = 2'd3;
    req_steps = 8'd4;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("done hold valid", int'(rsp_valid), 1);
    check("done hold status", int'(rsp_status), 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("in done");
    cur_tap = LOAD_TAP;

    // randomized requests against the model
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && rc == 2'd3) rc = 2'd1;
      rs = $urandom_range(0, 20);
      rf = 0;
      if (rs > 0 && $urandom_range(0, 3) == 0) rf = $urandom_range(1, rs);
      run_model(rc, rs, rf, $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
